// File: rtl/fab_rst_pkg.sv
// Shared types and helpers for the fabric reset sequencer.
// State encoding plus the counter-width computation used by the top level.
package fab_rst_pkg;

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_STABLE,
        S_REL_APB,
        S_RUN,
        S_SW_RST
    } state_t;

    // The counter holds values up to (largest terminal count - 1), so $clog2 of the largest is enough.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/fab_rst_sequencer_lock_sync.sv
// Two-flop synchronizer that brings the combined PLL lock into the clk domain.
// Both stages clear to 0 on reset, so lock always reads "not locked" after reset.
module lock_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state is always written with <= so every flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fab_rst_sequencer.sv
// Staged reset generator: qualifies PLL lock, releases APB then core, supports a core-only sw reset.
// Define FAB_RST_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module fab_rst_sequencer
    import fab_rst_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int SW_RST_CYCLES      = 8,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fab_lock,
    input  logic             mss_lock,
    input  logic             sw_rst_req,
    output logic             apb_rst_n,
    output logic             core_rst_n,
    output logic             sys_ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int CW = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP, SW_RST_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] SW_LAST   = CW'(SW_RST_CYCLES - 1);

    logic            lock_raw;
    logic            lock_s;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            apb_q, apb_d;
    logic            core_q, core_d;
    logic            ready_q, ready_d;

    assign lock_raw = fab_lock & mss_lock;

    lock_sync u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (lock_raw),
        .q     (lock_s)
    );

    // NOTE: every control flop, counters included, has an async reset so the sequence restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            apb_q   <= 1'b0;
            core_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            apb_q   <= apb_d;
            core_q  <= core_d;
            ready_q <= ready_d;
        end
    end

    // NOTE: every signal gets a hold default first, so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        apb_d   = apb_q;
        core_d  = core_q;
        ready_d = ready_q;
        if (state_q != S_WAIT_LOCK && !lock_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            apb_d   = 1'b0;
            core_d  = 1'b0;
            ready_d = 1'b0;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end
                end
                S_STABLE: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = S_REL_APB;
                        cnt_d   = '0;
                        apb_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_REL_APB: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        core_d  = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    if (sw_rst_req) begin
                        state_d = S_SW_RST;
                        cnt_d   = '0;
                        core_d  = 1'b0;
                        ready_d = 1'b0;
                    end
                end
                S_SW_RST: begin
                    if (cnt_q == SW_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        core_d  = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign apb_rst_n  = apb_q;
    assign core_rst_n = core_q;
    assign sys_ready  = ready_q;

`ifdef FAB_RST_LOCK_LOSS_CNT_EN
    // Losses during qualification are not counted; only losses after APB release are.
    logic             loss_event;
    logic [CNT_W-1:0] loss_q;

    assign loss_event = !lock_s &&
                        (state_q == S_REL_APB || state_q == S_RUN || state_q == S_SW_RST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_event && loss_q != '1) begin
            loss_q <= loss_q + CNT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_fab_rst_sequencer.sv
// Directed bench for fab_rst_sequencer with short timing parameters.
// Edge numbering: the first posedge that samples a raised lock is edge 0; apb release lands on edge 2+LSC.
module tb_fab_rst_sequencer;

    localparam int LSC = 8;
    localparam int GAP = 4;
    localparam int SWC = 3;
    localparam int CW  = 2;

`ifdef FAB_RST_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fab_lock = 1'b0;
    logic          mss_lock = 1'b0;
    logic          sw_rst_req = 1'b0;
    logic          apb_rst_n;
    logic          core_rst_n;
    logic          sys_ready;
    logic [CW-1:0] lock_loss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int loss_model = 0;

    always #5 clk = ~clk;

    fab_rst_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP          (GAP),
        .SW_RST_CYCLES      (SWC),
        .CNT_W              (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fab_lock      (fab_lock),
        .mss_lock      (mss_lock),
        .sw_rst_req    (sw_rst_req),
        .apb_rst_n     (apb_rst_n),
        .core_rst_n    (core_rst_n),
        .sys_ready     (sys_ready),
        .lock_loss_cnt (lock_loss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
        return CNT_EN ? loss_model : 0;
    endfunction

    task automatic set_lock(input logic v);
        fab_lock = v;
        mss_lock = v;
    endtask

    task automatic check_outs(input string tag, input logic apb, input logic core, input logic rdy);
        check({tag, ":apb"},  apb_rst_n,  apb);
        check({tag, ":core"}, core_rst_n, core);
        check({tag, ":rdy"},  sys_ready,  rdy);
    endtask

    task automatic count_loss();
        if (loss_model < 3) loss_model++;
    endtask

    // Locks are already high and first sampled at the next edge; walks through to S_RUN.
    task automatic release_seq(input string tag, input bit poke_sw);
        for (int i = 0; i < 2 + LSC; i++) begin
            tick();
            check({tag, ":apb_hold"}, apb_rst_n, 1'b0);
        end
        tick();
        check_outs({tag, ":apb_rel"}, 1'b1, 1'b0, 1'b0);
        if (poke_sw) sw_rst_req = 1'b1;
        for (int i = 0; i < GAP - 1; i++) begin
            tick();
            sw_rst_req = 1'b0;
            check({tag, ":core_hold"}, core_rst_n, 1'b0);
        end
        tick();
        check_outs({tag, ":core_rel"}, 1'b1, 1'b1, 1'b1);
        tick();
        check_outs({tag, ":run_hold"}, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset:cnt", lock_loss_cnt, exp_cnt());
        rst_n = 1'b1;

        // Only one lock high: nothing must release
        fab_lock = 1'b1;
        repeat (12) tick();
        check_outs("one_lock", 1'b0, 1'b0, 1'b0);

        // Power-up with both locks; sw request outside S_RUN must not be queued
        mss_lock = 1'b1;
        release_seq("pwrup", 1'b1);
        check("pwrup:cnt", lock_loss_cnt, exp_cnt());

        // Return to reset to set up the glitch scenario
        rst_n = 1'b0;
        #1;
        check_outs("rst_mid", 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Lock glitch low 3 cycles when the stable count has reached 5
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch:pre", apb_rst_n, 1'b0);
        end
        set_lock(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("glitch:low", apb_rst_n, 1'b0);
        end
        set_lock(1'b1);
        release_seq("glitch", 1'b0);
        check("glitch:cnt", lock_loss_cnt, exp_cnt());

        // Lock drop in S_RUN: outputs fall on the third edge
        set_lock(1'b0);
        tick();
        check_outs("drop:e0", 1'b1, 1'b1, 1'b1);
        tick();
        check_outs("drop:e1", 1'b1, 1'b1, 1'b1);
        tick();
        check_outs("drop:e2", 1'b0, 1'b0, 1'b0);
        count_loss();
        check("drop:cnt", lock_loss_cnt, exp_cnt());
        set_lock(1'b1);
        release_seq("relock", 1'b0);

        // Software reset: core low exactly SWC cycles; second pulse ignored
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check_outs("sw:e0", 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("sw:e1", 1'b1, 1'b0, 1'b0);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check_outs("sw:e2", 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("sw:e3", 1'b1, 1'b1, 1'b1);
        tick();
        check_outs("sw:e4", 1'b1, 1'b1, 1'b1);
        check("sw:cnt", lock_loss_cnt, exp_cnt());

        // Four more losses after APB release: counter saturates
        for (int n = 0; n < 4; n++) begin
            set_lock(1'b0);
            repeat (3) tick();
            check_outs("sat:drop", 1'b0, 1'b0, 1'b0);
            count_loss();
            check("sat:cnt", lock_loss_cnt, exp_cnt());
            set_lock(1'b1);
            repeat (2 + LSC) tick();
            check("sat:apb_hold", apb_rst_n, 1'b0);
            tick();
            check("sat:apb_rel", apb_rst_n, 1'b1);
        end
        repeat (GAP) tick();
        check_outs("sat:run", 1'b1, 1'b1, 1'b1);
        check("sat:final_cnt", lock_loss_cnt, exp_cnt());

        // Async reset while in S_SW_RST
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        check_outs("arst:swrst", 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        loss_model = 0;
        check_outs("arst:async", 1'b0, 1'b0, 1'b0);
        check("arst:cnt", lock_loss_cnt, exp_cnt());
        tick();
        check_outs("arst:held", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        release_seq("restart", 1'b0);
        check("restart:cnt", lock_loss_cnt, exp_cnt());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
